// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared helpers for the counter library
//
// Purpose:
//   Parameter legality check and the modulo arithmetic used by the
//   JK-based counters. All helpers work on 32-bit unsigned values, so a
//   caller sizes its result back down with a WIDTH'() cast.
//
// Contents:
//   MIN_WIDTH / MAX_WIDTH  legal counter width range
//   params_legal()         WIDTH/MOD legality, for elaboration checks
//   is_pow2()              power-of-two test on a modulus
//   clamp_mod()            limit a value to MOD-1
//   next_down()            wrapped decrement inside 0..MOD-1
package counter_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 8;

  function automatic bit params_legal(input int width, input int modulus);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned clamp_mod(input int unsigned val,
                                            input int unsigned modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

  // An out-of-range count restarts at the top of the range, the same value
  // that a wrap from zero produces.
  function automatic int unsigned next_down(input int unsigned cnt,
                                            input int unsigned modulus);
    return ((cnt == 0) || (cnt >= modulus)) ? (modulus - 1) : (cnt - 1);
  endfunction

endpackage

// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - JK flip-flop cell with asynchronous reset and set
//
// Purpose:
//   Library JK flip-flop. Reset dominates set; both act asynchronously.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset, q -> 0
//   set    asynchronous active-high set, q -> 1
//   j, k   00 hold, 01 clear, 10 set, 11 toggle
//   q      state
//   q_bar  complement of q
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or posedge rst or posedge set) begin
    if (rst) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_down_counter.sv
// rtl/jk_down_counter.sv - synchronous modulo-MOD down counter built from jk_ff cells
//
// Purpose:
//   Counts MOD-1 down to 0 and wraps, with parallel load (priority over
//   enable), a combinational terminal-count flag and a registered wrap pulse.
//   Every bit is one jk_ff on the common clock.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (out=0, wrap=0)
//   en        count enable, decrement by one per edge
//   load      synchronous load of min(load_val, MOD-1), wins over en
//   load_val  value to load
//   out       current count, out[0] is the LSB
//   tc        (out == 0) && en
//   wrap      one-cycle pulse while out first shows MOD-1 after a wrap
module jk_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  if (!params_legal(WIDTH, MOD)) begin : g_param_check
    $error("jk_down_counter: WIDTH must be 2..8 and MOD 2..2**WIDTH");
  end

  localparam bit MOD_POW2 = is_pow2(MOD);

  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] next_cnt;
  logic             cnt_zero;
  logic             illegal;
  logic             wrap_d;
  logic             force_bits;
  logic             toggle_mode;
  logic             low_zero;

  // All complements high means the count is zero.
  assign cnt_zero = &out_n;
  assign illegal  = (32'(out) >= MOD);
  assign tc       = cnt_zero & en;

  always_comb begin
    next_cnt    = out;
    wrap_d      = 1'b0;
    force_bits  = 1'b0;
    toggle_mode = 1'b0;
    if (load) begin
      next_cnt   = WIDTH'(clamp_mod(32'(load_val), MOD));
      force_bits = 1'b1;
    end else if (en) begin
      next_cnt = WIDTH'(next_down(32'(out), MOD));
      // An out-of-range count is reloaded silently, not reported as a wrap.
      wrap_d   = cnt_zero & ~illegal;
      // The pure toggle chain only yields the right value for an in-range,
      // non-wrapping decrement of a power-of-two modulus.
      if (cnt_zero || illegal || !MOD_POW2) begin
        force_bits = 1'b1;
      end else begin
        toggle_mode = 1'b1;
      end
    end
  end

  // Toggle form: bit i flips when every lower bit is zero (borrow ripple).
  // Forced form: J/K set each bit straight to its next value.
  always_comb begin
    j        = '0;
    k        = '0;
    low_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (force_bits) begin
        j[i] = next_cnt[i];
        k[i] = ~next_cnt[i];
      end else begin
        j[i] = toggle_mode & low_zero;
        k[i] = toggle_mode & low_zero;
      end
      low_zero = low_zero & out_n[i];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk   (clk),
      .rst   (rst),
      .set   (1'b0),
      .j     (j[i]),
      .k     (k[i]),
      .q     (out[i]),
      .q_bar (out_n[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_jk_down_counter.sv
// tb/tb_jk_down_counter.sv - self-checking bench for jk_down_counter
module tb_jk_down_counter;

  logic       clk = 1'b0;
  logic       rst8 = 1'b1;
  logic       rst5 = 1'b1;
  logic       en8, load8, en5, load5;
  logic [2:0] lv8, lv5;
  logic [2:0] out8, out5;
  logic       tc8, wrap8, tc5, wrap5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_down_counter #(.WIDTH(3), .MOD(8)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .load(load8), .load_val(lv8),
    .out(out8), .tc(tc8), .wrap(wrap8)
  );

  jk_down_counter #(.WIDTH(3), .MOD(5)) u_dut5 (
    .clk(clk), .rst(rst5), .en(en5), .load(load5), .load_val(lv5),
    .out(out5), .tc(tc5), .wrap(wrap5)
  );

  typedef struct {
    bit         ld;
    bit         en;
    logic [2:0] lv;
    bit         exp_tc;    // before the edge
    logic [2:0] exp_out;   // after the edge
    bit         exp_wrap;  // after the edge
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_5[$];

  task automatic check(input string what, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", what, idx, act, exp);
    end
  endtask

  // Entered just after a negedge; leaves just after the following negedge.
  task automatic step(input bit m5, input vec_t v, input string tag, input int idx);
    if (m5) begin en5 = v.en; load5 = v.ld; lv5 = v.lv; end
    else    begin en8 = v.en; load8 = v.ld; lv8 = v.lv; end
    #1;
    check({tag, "_tc"}, idx, m5 ? tc5 : tc8, v.exp_tc);
    @(posedge clk);
    #1;
    check({tag, "_out"}, idx, m5 ? out5 : out8, v.exp_out);
    check({tag, "_wrap"}, idx, m5 ? wrap5 : wrap8, v.exp_wrap);
    @(negedge clk);
  endtask

  task automatic run_tab(input bit m5, input vec_t t[$], input string tag);
    foreach (t[i]) step(m5, t[i], tag, i);
  endtask

  task automatic do_reset(input bit m5);
    @(negedge clk);
    if (m5) begin rst5 = 1'b1; en5 = 1'b1; load5 = 1'b0; lv5 = 3'd0; end
    else    begin rst8 = 1'b1; en8 = 1'b1; load8 = 1'b0; lv8 = 3'd0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  m5, m5 ? out5 : out8, 0);
    check("rst_wrap", m5, m5 ? wrap5 : wrap8, 0);
    check("rst_tc",   m5, m5 ? tc5 : tc8, 1);
    @(negedge clk);
    if (m5) rst5 = 1'b0;
    else    rst8 = 1'b0;
  endtask

  initial begin
    en8 = 1'b0; load8 = 1'b0; lv8 = 3'd0;
    en5 = 1'b0; load5 = 1'b0; lv5 = 3'd0;

    //            ld  en  lv    tc  out   wrap
    tab_a.push_back('{0, 1, 3'd0, 1, 3'd7, 1});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd6, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd5, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd4, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd3, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd2, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd1, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd0, 0});
    tab_a.push_back('{0, 1, 3'd0, 1, 3'd7, 1});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd6, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd5, 0});
    tab_a.push_back('{1, 1, 3'd3, 0, 3'd3, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd2, 0});
    tab_a.push_back('{0, 1, 3'd0, 0, 3'd1, 0});
    tab_a.push_back('{1, 0, 3'd2, 0, 3'd2, 0});

    tab_b.push_back('{1, 0, 3'd0, 0, 3'd0, 0});
    tab_b.push_back('{1, 1, 3'd2, 1, 3'd2, 0});
    tab_b.push_back('{1, 0, 3'd6, 0, 3'd6, 0});

    tab_5.push_back('{0, 1, 3'd0, 1, 3'd4, 1});
    tab_5.push_back('{0, 1, 3'd0, 0, 3'd3, 0});
    tab_5.push_back('{0, 1, 3'd0, 0, 3'd2, 0});
    tab_5.push_back('{0, 1, 3'd0, 0, 3'd1, 0});
    tab_5.push_back('{0, 1, 3'd0, 0, 3'd0, 0});
    tab_5.push_back('{0, 1, 3'd0, 1, 3'd4, 1});
    tab_5.push_back('{1, 0, 3'd6, 0, 3'd4, 0});
    tab_5.push_back('{1, 0, 3'd2, 0, 3'd2, 0});
    tab_5.push_back('{1, 0, 3'd7, 0, 3'd4, 0});
    tab_5.push_back('{1, 0, 3'd1, 0, 3'd1, 0});
    tab_5.push_back('{1, 1, 3'd5, 0, 3'd4, 0});
    tab_5.push_back('{1, 0, 3'd4, 0, 3'd4, 0});
    tab_5.push_back('{0, 1, 3'd0, 0, 3'd3, 0});

    // Eight-state counter: count, load priority, load to 2
    do_reset(0);
    run_tab(0, tab_a, "m8a");

    // Enable hold with a wandering load_val
    for (int i = 0; i < 4; i++) begin
      en8 = 1'b0; load8 = 1'b0; lv8 = 3'($urandom_range(0, 7));
      #1;
      check("hold_tc", i, tc8, 0);
      @(posedge clk);
      #1;
      check("hold_out", i, out8, 2);
      check("hold_wrap", i, wrap8, 0);
      @(negedge clk);
    end

    // Load at terminal count, then park at 6
    run_tab(0, tab_b, "m8b");

    // Asynchronous reset between edges while out=6 and load=1
    en8 = 1'b1; load8 = 1'b1; lv8 = 3'd1;
    #2 rst8 = 1'b1;
    #1;
    check("arst_out", 0, out8, 0);
    check("arst_wrap", 0, wrap8, 0);
    check("arst_tc", 0, tc8, 1);
    rst8 = 1'b0; load8 = 1'b0; en8 = 1'b1;
    @(posedge clk);
    #1;
    check("arst_next_out", 0, out8, 7);
    check("arst_next_wrap", 0, wrap8, 1);
    @(negedge clk);

    // Five-state counter: count sequence and clamping
    do_reset(1);
    run_tab(1, tab_5, "m5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_down_counter.md
Name: jk_down_counter

Overview:
- Synchronous modulo-MOD down counter built from the team's jk_ff cells.
- It is the counting-direction complement of the 3-bit JK up counter.
- All flip-flops share one clock, so there is no ripple clocking.
- Adds parallel load, count enable, a terminal-count flag and a registered wrap pulse, so it can serve as a countdown/timeout source in the counter library.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..8.
- MOD, 8, count modulus; legal range 2..2**WIDTH. The count sequence is MOD-1 down to 0, then wraps.

Ports:
- clk  input  1  single clock; all flip-flops update on the rising edge.
- rst  input  1  asynchronous, active-high reset, wired to the rst pin of every jk_ff.
- en  input  1  count enable; when high, decrement by one per clk edge.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value loaded when load=1.
- out  output  WIDTH  current count; out[0] is the LSB.
- tc  output  1  combinational terminal count: (out==0) && en.
- wrap  output  1  registered one-cycle pulse, high in the cycle after the counter wraps from 0 to MOD-1.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count or mid-load): out=0 and wrap=0 immediately. tc is then equal to en. The set pins of all jk_ff are tied to 0.
- Reset release: the first rising edge with rst=0 is a normal evaluation edge. No extra synchronisation cycle.
- Next-state priority on each rising edge:
  - load=1: out <= min(load_val, MOD-1). A load_val >= MOD is clamped to MOD-1. wrap <= 0. en is ignored.
  - load=0, en=1, out!=0: out <= out-1. wrap <= 0.
  - load=0, en=1, out==0: out <= MOD-1. wrap <= 1.
  - load=0, en=0: out holds. wrap <= 0.
- Latency: out reflects load or decrement one clock after the controlling inputs are sampled. wrap asserts in the same cycle out first shows MOD-1 after a wrap.
- JK drive, plain decrement when MOD is a power of two and not wrapping: J=K=1 on bit i iff en && out[i-1:0]==0. Bit 0 toggles whenever en=1.
- JK drive, load or wrap cycles, and every decrement when MOD is not a power of two: force each bit with J=next[i], K=~next[i].
- Illegal states: out >= MOD can only arise from a glitch. If it occurs, the next enabled edge loads MOD-1 and does not assert wrap.
- Simultaneous load=1 and tc=1: load wins and wrap stays 0. tc still reads 1 combinationally during that cycle.
- No X propagation: with en=0 and load=0, out holds regardless of load_val.

Decomposition:
- Shared package counter_pkg:
  - WIDTH/MOD legality check as a function, used by elaboration-time assertions.
  - Function clamp_mod(val, MOD).
  - Function next_down(out, MOD) returning the wrapped decrement.
- Sub-module: reuse the existing jk_ff, instantiated once per bit (ports j, k, rst, set, clk, q, q_bar).
- Keep in jk_down_counter: next-state and JK-input logic, the wrap register, and the tc assign.
- No further sub-modules.

Test Plan:
- Reset then count: assert rst for 2 cycles, then release with en=1, load=0, default params. Required out sequence: 0, 7, 6, 5, 4, 3, 2, 1, 0, 7. wrap is high only in the cycles where out=7. tc is high when out=0.
- Load priority: at out=5 drive load=1, load_val=3, en=1 for one edge. Required: out=3 next cycle (not 4), wrap=0, then 2, 1.
- Non-power-of-two modulus: WIDTH=3, MOD=5, en=1 from reset. Required out: 0, 4, 3, 2, 1, 0, 4. Clamp check: load_val=6 gives out=4.
- Enable hold: en=0 for 4 cycles at out=2 while toggling load_val randomly. Required: out stays 2, wrap=0, tc=0.
- Async reset mid-operation: assert rst between edges while out=6 and load=1. Required: out=0 and wrap=0 before the next edge. After release, the first enabled edge gives out=7 with wrap=1.
- Simultaneous load at terminal count: out=0, en=1, load=1, load_val=2. Required: tc=1 before the edge; out=2 and wrap=0 after the edge.
